// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

   localparam int DIV_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Width of a down-counter that must hold the value w itself.
   function automatic int div_cnt_w(input int w);
      return (w < 2) ? 1 : $clog2(w + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, try to
// subtract the divisor, keep the difference only when it did not go negative.
module div_step #(
   parameter int W = 4
) (
   input  logic [W-1:0] rem_i,
   input  logic         bit_in_i,
   input  logic [W-1:0] dvs_i,
   output logic [W-1:0] rem_next_o,
   output logic         qbit_o
);

   // The shifted partial remainder is W+1 bits wide. Its top bit set means it
   // is certainly >= the W-bit divisor, so only the low W bits need a real
   // subtractor; the true difference then always fits back into W bits.
   logic [W:0] sh;
   logic [W:0] diff;

   assign sh         = {rem_i, bit_in_i};
   assign diff       = {1'b0, sh[W-1:0]} - {1'b0, dvs_i};
   assign qbit_o     = sh[W] | ~diff[W];
   assign rem_next_o = qbit_o ? diff[W-1:0] : sh[W-1:0];

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_DBZ_EN: divide-by-zero fast path straight to DONE
// with dz set; when undefined, b==0 runs the full W steps and dz is 0.
module div_seq
   import div_pkg::*;
#(
   parameter int W = DIV_W_DEF
) (
   input  logic         ck,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] q,
   output logic [W-1:0] r,
   output logic         busy,
   output logic         done,
   output logic         dz
);

   localparam int CW = div_cnt_w(W);

   div_state_t    state_q, state_d;
   logic [W-1:0]  dvd_q, dvd_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  q_q, q_d;
   logic [W-1:0]  r_q, r_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  rem_step;
   logic          qbit;
`ifdef DIV_DBZ_EN
   logic          dz_q, dz_d;
`endif

   div_step #(.W(W)) u_step (
      .rem_i      (rem_q),
      .bit_in_i   (dvd_q[W-1]),
      .dvs_i      (dvs_q),
      .rem_next_o (rem_step),
      .qbit_o     (qbit)
   );

   // Next-state logic: accept in IDLE/DONE, iterate in RUN, publish on last step.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
`ifdef DIV_DBZ_EN
      dz_d    = dz_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               dvd_d   = a;
               dvs_d   = b;
               rem_d   = '0;
               cnt_d   = CW'(W);
               state_d = RUN;
`ifdef DIV_DBZ_EN
               if (b == '0) begin
                  q_d     = '1;
                  r_d     = a;
                  dz_d    = 1'b1;
                  state_d = DONE;
               end
`endif
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            dvd_d = {dvd_q[W-2:0], qbit};
            rem_d = rem_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               q_d     = {dvd_q[W-2:0], qbit};
               r_d     = rem_step;
               state_d = DONE;
`ifdef DIV_DBZ_EN
               dz_d    = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset abandons any operation and clears the results.
   always_ff @(posedge ck) begin
      if (rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
`ifdef DIV_DBZ_EN
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
`ifdef DIV_DBZ_EN
         dz_q    <= dz_d;
`endif
      end
   end

   assign q    = q_q;
   assign r    = r_q;
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
`ifdef DIV_DBZ_EN
   assign dz   = dz_q;
`else
   assign dz   = 1'b0;
`endif

endmodule
